// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// ------------------------------------------------------------------------
// UART transmit framer. Accepts one parallel word per TX_DATA_VALID strobe
// while idle and serialises it at one bit per clk cycle:
//     start (0), data LSB first, optional parity, stop (1).
// TX_OUT and busy are driven straight from flops. The flops are loaded with
// the value for the state being entered, so the start bit appears in the
// cycle after the edge that samples the strobe.
//
// Optional build macro: UART_TX_TWO_STOP_EN
//     defined   -> two stop bits, counted by a 1-bit stop counter
//     undefined -> one stop bit, and no stop counter flop exists
//
// Ports:
//     clk            bit-rate clock (one cycle per bit period)
//     rst            asynchronous, active-low reset
//     P_DATA         parallel word to transmit
//     TX_DATA_VALID  strobe; P_DATA/PAR_EN/PAR_TYP are sampled in IDLE only
//     PAR_EN         1 = append a parity bit after the data bits
//     PAR_TYP        0 = even parity, 1 = odd parity
//     TX_OUT         serial line, idle high
//     busy           high while a frame is in flight
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  TX_DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_typ_reg, par_typ_next;
    logic                  tx_reg, tx_next;
    logic                  busy_reg, busy_next;
    logic [CW-1:0]         cnt_inc;
    logic                  parity_bit;

    // Parity always comes from the latched copies, never from live inputs.
    assign parity_bit = (^data_reg) ^ par_typ_reg;
    assign cnt_inc    = cnt_reg + 1'b1;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt_reg, stop_cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_cnt_reg <= 1'b0;
        end else begin
            stop_cnt_reg <= stop_cnt_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            cnt_reg     <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            cnt_reg     <= cnt_next;
            par_en_reg  <= par_en_next;
            par_typ_reg <= par_typ_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // Next state plus the output values that go with the state being entered.
    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        cnt_next     = cnt_reg;
        par_en_next  = par_en_reg;
        par_typ_next = par_typ_reg;
        tx_next      = 1'b1;
        busy_next    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_next = stop_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (TX_DATA_VALID) begin
                    state_next   = START;
                    data_next    = P_DATA;
                    par_en_next  = PAR_EN;
                    par_typ_next = PAR_TYP;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt_next = 1'b0;
`endif
                end
            end
            START: begin
                state_next = DATA;
                cnt_next   = '0;
                tx_next    = data_reg[0];
            end
            DATA: begin
                if (cnt_reg == LAST_BIT) begin
                    cnt_next = '0;
                    if (par_en_reg) begin
                        state_next = PARITY;
                        tx_next    = parity_bit;
                    end else begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    tx_next  = data_reg[cnt_inc];
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                // First stop cycle stays in STOP; the second one leaves.
                if (!stop_cnt_reg) begin
                    stop_cnt_next = 1'b1;
                end else begin
                    stop_cnt_next = 1'b0;
                    state_next    = IDLE;
                    busy_next     = 1'b0;
                end
`else
                state_next = IDLE;
                busy_next  = 1'b0;
`endif
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// ------------------------------------------------------------------------
// Self-checking bench for uart_tx_frame (DATA_WIDTH = 8). Directed vectors
// come from a table, corner cases are hand-written sequences, and a random
// loop is checked against a frame model built from the framing rules.
// Honours UART_TX_TWO_STOP_EN to expect one or two stop bits.
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       tx_data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int total;
    int bad;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .P_DATA        (p_data),
        .TX_DATA_VALID (tx_data_valid),
        .PAR_EN        (par_en),
        .PAR_TYP       (par_typ),
        .TX_OUT        (tx_out),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        bit         mid;
        int         exp_len;
        int         exp_par;   // -1 when the frame has no parity bit
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, " idle tx"}, int'(tx_out), 1);
            check({name, " idle busy"}, int'(busy), 0);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity so the ones count of
    // data+parity is even (pt=0) or odd (pt=1), then STOPS ones.
    function automatic void build_frame(input logic [7:0] d, input logic pe,
                                        input logic pt, output int q[$]);
        q.delete();
        q.push_back(0);
        for (int i = 0; i < 8; i++) q.push_back(int'(d[i]));
        if (pe) q.push_back(($countones(d) + int'(pt)) % 2);
        for (int i = 0; i < STOPS; i++) q.push_back(1);
    endfunction

    // Called at a negedge. Strobes for one cycle, records TX_OUT while busy,
    // and returns at the negedge of the first idle cycle, so an immediate
    // further call strobes in that first idle cycle (back-to-back).
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input bit mid, input int exp_len, input int exp_par,
                             input string name);
        int  model[$];
        int  obs[$];
        bit  done;
        int  n;
        build_frame(d, pe, pt, model);
        p_data        = d;
        par_en        = pe;
        par_typ       = pt;
        tx_data_valid = 1'b1;
        done          = 1'b0;
        for (int cyc = 0; cyc < 24 && !done; cyc++) begin
            @(negedge clk);
            if (mid && cyc == 3) begin
                // Junk inputs and a stray strobe in the middle of DATA.
                p_data        = ~d;
                par_typ       = ~pt;
                par_en        = ~pe;
                tx_data_valid = 1'b1;
            end else begin
                tx_data_valid = 1'b0;
            end
            if (busy) begin
                obs.push_back(int'(tx_out));
            end else begin
                done = 1'b1;
                check({name, " idle after frame"}, int'(tx_out), 1);
            end
        end
        check({name, " busy ended"}, int'(done), 1);
        check({name, " busy cycles"}, obs.size(), model.size());
        if (exp_len >= 0) check({name, " frame length"}, obs.size(), exp_len);
        n = (obs.size() < model.size()) ? obs.size() : model.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s bit%0d", name, i), obs[i], model[i]);
        end
        if (exp_par >= 0) begin
            if (obs.size() > 9) check({name, " parity"}, obs[9], exp_par);
            else check({name, " parity present"}, obs.size(), 10);
        end
        $display("frame %s data=%02h pe=%0d pt=%0d busy_cycles=%0d", name, d, pe, pt, obs.size());
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        p_data        = 8'h00;
        tx_data_valid = 1'b0;
        par_en        = 1'b0;
        par_typ       = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 2 + 8 + STOPS - 1, -1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 3 + 8 + STOPS - 1, 1};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 3 + 8 + STOPS - 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 3 + 8 + STOPS - 1, 0};

        // Reset held for three cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset tx", int'(tx_out), 1);
            check("reset busy", int'(busy), 0);
        end
        rst = 1'b1;
        idle_cycles(5, "post reset");

        // Directed table.
        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].mid,
                      vecs[i].exp_len, vecs[i].exp_par, $sformatf("vec%0d", i));
            idle_cycles(3, $sformatf("vec%0d", i));
        end

        // Back-to-back: second strobe in the first idle cycle.
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 9 + STOPS, -1, "b2b_a");
        run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 9 + STOPS, -1, "b2b_b");
        idle_cycles(2, "b2b");

        // Reset during the 4th data bit of 0x55.
        p_data        = 8'h55;
        par_en        = 1'b0;
        par_typ       = 1'b0;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        check("rstmid start", int'(tx_out), 0);
        repeat (4) @(negedge clk);
        check("rstmid bit3", int'(tx_out), 0);
        check("rstmid busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("rstmid async tx", int'(tx_out), 1);
        check("rstmid async busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(5, "rstmid");
        $display("frame rstmid data=55 aborted at bit3");

        // Random frames against the model.
        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            bit         mid;
            d   = 8'($urandom);
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            mid = 1'($urandom_range(0, 1));
            run_frame(d, pe, pt, mid, 10 + int'(pe) + STOPS - 1, -1, $sformatf("rnd%0d", r));
            idle_cycles($urandom_range(0, 2), $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
